mem_access: RTL and testbench

Memory-access pipeline stage directly downstream of the execute stage. It consumes the execute stage's registered outputs and performs loads and stores over a single-outstanding req/ack data bus. Load data is aligned and sign/zero-extended; store data is lane-replicated with byte enables generated. Misaligned accesses raise an exception instead of reaching the bus. All other instructions pass through to write-back in one cycle.

---
 rtl/mem_access.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage that sits after the execute stage.
// Loads and stores go over a req/ack data bus that allows one outstanding
// transaction. Load data is aligned and sign- or zero-extended. Store data is
// replicated across the byte lanes and the byte enables are generated from the
// address. A misaligned access raises an exception and never reaches the bus.
// Every other instruction passes through to write-back in one cycle.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   stall_i, flush_i         hold / clear the write-back output registers
//   pc_i .. exceptionpc_i    instruction fields from the execute stage
//   bus_*_o, bus_*_i         single-outstanding data bus (req held until ack)
//   pc_o .. system_ret_o     registered fields to write-back
//   mem_stall_o              combinational request to stall IF..EXE
module mem_access #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rd_data_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_we_i,
  input  logic            mem_re_i,
  input  logic            mem_we_i,
  input  logic [2:0]      opfunc3_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_data_i,
  input  logic            csr_we_i,
  input  logic            system_ret_i,
  input  logic [XLEN-1:0] exception_i,
  input  logic [XLEN-1:0] exceptionpc_i,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [XLEN-1:0] bus_wdata_o,
  output logic [3:0]      bus_be_o,
  input  logic [XLEN-1:0] bus_rdata_i,
  input  logic            bus_ack_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic [XLEN-1:0] csr_data_o,
  output logic [XLEN-1:0] exception_o,
  output logic [XLEN-1:0] exceptionpc_o,
  output logic [4:0]      rd_addr_o,
  output logic [11:0]     csr_addr_o,
  output logic            rd_we_o,
  output logic            csr_we_o,
  output logic            system_ret_o,
  output logic            mem_stall_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] EXC_LOAD_MISALIGNED  = XLEN'(4);
  localparam logic [XLEN-1:0] EXC_STORE_MISALIGNED = XLEN'(6);

  state_t          state;
  logic            drop;       // flushed while BUSY: discard the result on ack
  logic [2:0]      ld_func3;   // load size/sign latched at request time
  logic [1:0]      ld_lane;    // load byte lane latched at request time
  logic [XLEN-1:0] load_res;   // formatted load data awaiting write-back

  logic [1:0]      lane;
  logic            access;
  logic            misaligned;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_fmt;

  // Access decode and stall request
  always_comb begin
    lane       = mem_addr_i[1:0];
    access     = (mem_re_i | mem_we_i) & (exception_i == '0);
    misaligned = access &
                 (((opfunc3_i[1:0] == 2'b01) & lane[0]) |
                  ((opfunc3_i[1:0] == 2'b10) & (lane != 2'b00)));
    // The drop term keeps the pipe stalled until a flushed transaction is
    // acknowledged, even though the flushed instruction is no longer presented.
    mem_stall_o = (access & ~misaligned & (state != DONE)) |
                  ((state == BUSY) & drop);
  end

  // Store lane replication and byte enables
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = rd_data_i;
    case (opfunc3_i[1:0])
      2'b00: begin
        st_be    = 4'b0001 << lane;
        st_wdata = {4{rd_data_i[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {lane[1], 1'b0};
        st_wdata = {2{rd_data_i[15:0]}};
      end
      2'b10: begin
        st_be    = 4'b1111;
        st_wdata = rd_data_i;
      end
      default: begin
        st_be    = 4'b0000;
        st_wdata = rd_data_i;
      end
    endcase
  end

  // Load lane selection and extension
  always_comb begin
    case (ld_lane)
      2'd0:    ld_byte = bus_rdata_i[7:0];
      2'd1:    ld_byte = bus_rdata_i[15:8];
      2'd2:    ld_byte = bus_rdata_i[23:16];
      default: ld_byte = bus_rdata_i[31:24];
    endcase
    ld_half = ld_lane[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (ld_func3)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'h000000, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'h0000, ld_half};
      3'b010:  ld_fmt = bus_rdata_i;
      default: ld_fmt = '0;
    endcase
  end

  // Bus FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      drop        <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_be_o    <= '0;
      ld_func3    <= '0;
      ld_lane     <= '0;
      load_res    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A flushed instruction must not start a transaction (stores have
          // side effects on the bus).
          if (access & ~misaligned & ~flush_i) begin
            state       <= BUSY;
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= {mem_addr_i[XLEN-1:2], 2'b00};
            bus_wdata_o <= st_wdata;
            bus_be_o    <= st_be;
            ld_func3    <= opfunc3_i;
            ld_lane     <= lane;
          end
        end
        BUSY: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            drop      <= 1'b0;
            if (drop | flush_i) begin
              state <= IDLE;
            end else begin
              state <= DONE;
              if (~bus_we_o) load_res <= ld_fmt;
            end
          end else if (flush_i) begin
            drop <= 1'b1;
          end
        end
        DONE: begin
          if (flush_i | ~stall_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back output registers. Reset/flush and the memory-stall bubble both
  // clear; stall_i holds, and it outranks the bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i | flush_i | (~stall_i & mem_stall_o)) begin
      pc_o          <= '0;
      rd_data_o     <= '0;
      csr_data_o    <= '0;
      exception_o   <= '0;
      exceptionpc_o <= '0;
      rd_addr_o     <= '0;
      csr_addr_o    <= '0;
      rd_we_o       <= 1'b0;
      csr_we_o      <= 1'b0;
      system_ret_o  <= 1'b0;
    end else if (~stall_i) begin
      pc_o         <= pc_i;
      rd_data_o    <= (access & mem_re_i & ~misaligned) ? load_res : rd_data_i;
      csr_data_o   <= csr_data_i;
      rd_addr_o    <= rd_addr_i;
      csr_addr_o   <= csr_addr_i;
      system_ret_o <= system_ret_i;
      if (misaligned) begin
        exception_o   <= mem_re_i ? EXC_LOAD_MISALIGNED : EXC_STORE_MISALIGNED;
        exceptionpc_o <= pc_i;
        rd_we_o       <= 1'b0;
        csr_we_o      <= 1'b0;
      end else begin
        exception_o   <= exception_i;
        exceptionpc_o <= exceptionpc_i;
        rd_we_o       <= rd_we_i;
        csr_we_o      <= csr_we_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected bus transactions
// and expected write-back records into queues; a monitor pops and compares
// whenever the DUT raises a bus request or presents a new instruction.
module tb_mem_access;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i;
  logic [31:0] pc_i, rd_data_i, mem_addr_i, csr_data_i, exception_i, exceptionpc_i;
  logic [4:0]  rd_addr_i;
  logic        rd_we_i, mem_re_i, mem_we_i, csr_we_i, system_ret_i;
  logic [2:0]  opfunc3_i;
  logic [11:0] csr_addr_i;
  logic        bus_req_o, bus_we_o, bus_ack_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_be_o;
  logic [31:0] pc_o, rd_data_o, csr_data_o, exception_o, exceptionpc_o;
  logic [4:0]  rd_addr_o;
  logic [11:0] csr_addr_o;
  logic        rd_we_o, csr_we_o, system_ret_o, mem_stall_o;

  mem_access #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .pc_i(pc_i), .rd_data_i(rd_data_i), .mem_addr_i(mem_addr_i),
    .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i), .mem_re_i(mem_re_i),
    .mem_we_i(mem_we_i), .opfunc3_i(opfunc3_i), .csr_addr_i(csr_addr_i),
    .csr_data_i(csr_data_i), .csr_we_i(csr_we_i), .system_ret_i(system_ret_i),
    .exception_i(exception_i), .exceptionpc_i(exceptionpc_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .pc_o(pc_o), .rd_data_o(rd_data_o),
    .csr_data_o(csr_data_o), .exception_o(exception_o),
    .exceptionpc_o(exceptionpc_o), .rd_addr_o(rd_addr_o),
    .csr_addr_o(csr_addr_o), .rd_we_o(rd_we_o), .csr_we_o(csr_we_o),
    .system_ret_o(system_ret_o), .mem_stall_o(mem_stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] pc, rd_data, exc, excpc, csr_data;
    logic [4:0]  rd;
    logic        rd_we, csr_we, sret;
    logic [11:0] csr_addr;
  } wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void check32(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void exp_bus(input logic [31:0] addr, input logic we,
                                  input logic [3:0] be, input logic [31:0] wdata);
    bus_t b;
    b.addr = addr; b.we = we; b.be = be; b.wdata = wdata;
    bus_q.push_back(b);
  endfunction

  function automatic void exp_wb(input logic [31:0] pc, input logic [31:0] rd_data,
                                 input logic [4:0] rd, input logic rd_we,
                                 input logic [31:0] exc, input logic [31:0] excpc,
                                 input logic [11:0] csr_addr, input logic [31:0] csr_data,
                                 input logic csr_we, input logic sret);
    wb_t w;
    w.pc = pc; w.rd_data = rd_data; w.rd = rd; w.rd_we = rd_we; w.exc = exc;
    w.excpc = excpc; w.csr_addr = csr_addr; w.csr_data = csr_data;
    w.csr_we = csr_we; w.sret = sret;
    wb_q.push_back(w);
  endfunction

  // Monitor
  logic        req_prev = 1'b0;
  logic [31:0] last_pc = 32'h0;
  bus_t        cur_bus;

  always @(negedge clk_i) begin
    if (bus_req_o === 1'b1 && req_prev !== 1'b1) begin
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_bus_req: got addr %h expected no request", bus_addr_o);
        cur_bus.addr = bus_addr_o; cur_bus.we = bus_we_o;
        cur_bus.be = bus_be_o; cur_bus.wdata = bus_wdata_o;
      end else begin
        cur_bus = bus_q.pop_front();
        check32("bus_addr", bus_addr_o, cur_bus.addr);
        check32("bus_we", {31'b0, bus_we_o}, {31'b0, cur_bus.we});
        check32("bus_be", {28'b0, bus_be_o}, {28'b0, cur_bus.be});
        if (cur_bus.we) check32("bus_wdata", bus_wdata_o, cur_bus.wdata);
      end
    end else if (bus_req_o === 1'b1) begin
      check32("bus_addr_hold", bus_addr_o, cur_bus.addr);
      check32("bus_be_hold", {28'b0, bus_be_o}, {28'b0, cur_bus.be});
    end
    req_prev = bus_req_o;

    if (pc_o !== last_pc && pc_o !== 32'h0 && !$isunknown(pc_o)) begin
      if (wb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_wb: got pc %h expected no instruction", pc_o);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        check32("wb_pc", pc_o, e.pc);
        check32("wb_rd_data", rd_data_o, e.rd_data);
        check32("wb_rd_addr", {27'b0, rd_addr_o}, {27'b0, e.rd});
        check32("wb_rd_we", {31'b0, rd_we_o}, {31'b0, e.rd_we});
        check32("wb_exception", exception_o, e.exc);
        check32("wb_exceptionpc", exceptionpc_o, e.excpc);
        check32("wb_csr_addr", {20'b0, csr_addr_o}, {20'b0, e.csr_addr});
        check32("wb_csr_data", csr_data_o, e.csr_data);
        check32("wb_csr_we", {31'b0, csr_we_o}, {31'b0, e.csr_we});
        check32("wb_sret", {31'b0, system_ret_o}, {31'b0, e.sret});
      end
    end
    last_pc = pc_o;
  end

  task automatic clear_inputs();
    pc_i = 0; rd_data_i = 0; mem_addr_i = 0; rd_addr_i = 0; rd_we_i = 0;
    mem_re_i = 0; mem_we_i = 0; opfunc3_i = 0; csr_addr_i = 0; csr_data_i = 0;
    csr_we_i = 0; system_ret_i = 0; exception_i = 0; exceptionpc_i = 0;
  endtask

  // Presents one instruction, answers the bus after 'waits' BUSY cycles,
  // optionally stalls for 'done_stall' cycles after the ack, and returns once
  // the stage has captured the instruction. Called just after a posedge.
  task automatic issue(input logic re, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] pc, input logic [4:0] rd, input logic rdwe,
                       input int waits, input logic [31:0] rdata, input int done_stall,
                       output int req_cyc, output int stall_cyc);
    int  busy_n, ds;
    bit  post_ack, done;
    mem_re_i = re; mem_we_i = we; opfunc3_i = f3; mem_addr_i = addr;
    rd_data_i = data; pc_i = pc; rd_addr_i = rd; rd_we_i = rdwe;
    busy_n = 0; ds = 0; post_ack = 0; req_cyc = 0; stall_cyc = 0; done = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      bus_ack_i   = (bus_req_o === 1'b1) && (busy_n == waits);
      bus_rdata_i = bus_ack_i ? rdata : 32'h0;
      stall_i     = post_ack && (ds < done_stall);
      if (stall_i) ds++;
      if (bus_req_o === 1'b1) busy_n++;
      @(negedge clk_i);
      if (mem_stall_o) stall_cyc++;
      if (bus_req_o) req_cyc++;
      if (stall_i) check32("done_hold_pc", pc_o, 32'h0);
      done = !mem_stall_o && !stall_i;
      if (bus_ack_i) post_ack = 1;
      @(posedge clk_i); #1;
      if (done) break;
      if (cyc == 63) begin
        checks++; errors++;
        $display("FAIL issue_timeout: got no capture for pc %h expected capture within 64 cycles", pc);
      end
    end
    bus_ack_i = 0; bus_rdata_i = 0; stall_i = 0;
    clear_inputs();
  endtask

  int rq, st;

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    stall_i = 0; flush_i = 0; bus_ack_i = 0; bus_rdata_i = 0; rst_i = 1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check32("rst_pc", pc_o, 0);
    check32("rst_rd_data", rd_data_o, 0);
    check32("rst_exc", exception_o, 0);
    check32("rst_rd_we", {31'b0, rd_we_o}, 0);
    check32("rst_bus_req", {31'b0, bus_req_o}, 0);
    check32("rst_bus_addr", bus_addr_o, 0);
    check32("rst_bus_be", {28'b0, bus_be_o}, 0);
    check32("rst_stall", {31'b0, mem_stall_o}, 0);
    @(posedge clk_i); #1; rst_i = 0;

    // ALU pass-through with CSR fields
    csr_addr_i = 12'h300; csr_data_i = 32'hAAAA5555; csr_we_i = 1; system_ret_i = 1;
    exp_wb(32'h1000, 32'h12345678, 5, 1, 0, 0, 12'h300, 32'hAAAA5555, 1, 1);
    issue(0, 0, 3'b000, 32'h0, 32'h12345678, 32'h1000, 5, 1, 0, 0, 0, rq, st);
    check32("alu_stall_cycles", st, 0);

    // sw 0x100, two wait cycles
    exp_bus(32'h100, 1, 4'hF, 32'hDEADBEEF);
    exp_wb(32'h1004, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h1004, 0, 0, 2, 0, 0, rq, st);
    check32("sw_req_cycles", rq, 3);
    check32("sw_stall_cycles", st, 4);

    // lb 0x203
    exp_bus(32'h200, 0, 4'b1000, 0);
    exp_wb(32'h1008, 32'hFFFFFF80, 7, 1, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 3'b000, 32'h203, 0, 32'h1008, 7, 1, 0, 32'h80FF1234, 0, rq, st);
    check32("lb_req_cycles", rq, 1);
    check32("lb_stall_cycles", st, 2);

    // lh 0x202, one wait cycle
    exp_bus(32'h200, 0, 4'b1100, 0);
    exp_wb(32'h100C, 32'hFFFF8001, 8, 1, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 3'b001, 32'h202, 0, 32'h100C, 8, 1, 1, 32'h80011234, 0, rq, st);
    check32("lh_stall_cycles", st, 3);

    // sh 0x002
    exp_bus(32'h000, 1, 4'b1100, 32'hABCDABCD);
    exp_wb(32'h1010, 32'h0000ABCD, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 3'b001, 32'h002, 32'h0000ABCD, 32'h1010, 0, 0, 0, 0, 0, rq, st);

    // lw 0x006: misaligned load
    exp_wb(32'h1014, 32'h0, 9, 0, 4, 32'h1014, 0, 0, 0, 0);
    issue(1, 0, 3'b010, 32'h006, 0, 32'h1014, 9, 1, 0, 0, 0, rq, st);
    check32("lw_mis_req_cycles", rq, 0);
    check32("lw_mis_stall_cycles", st, 0);

    // sh 0x001: misaligned store, csr_we suppressed
    csr_we_i = 1;
    exp_wb(32'h1018, 32'h5555, 0, 0, 6, 32'h1018, 0, 0, 0, 0);
    issue(0, 1, 3'b001, 32'h001, 32'h5555, 32'h1018, 0, 0, 0, 0, 0, rq, st);
    check32("sh_mis_req_cycles", rq, 0);

    // Upstream exception on a load: not an access, passes through
    exception_i = 2; exceptionpc_i = 32'h5000;
    exp_wb(32'h101C, 32'h77, 3, 0, 2, 32'h5000, 0, 0, 0, 0);
    issue(1, 0, 3'b010, 32'h007, 32'h77, 32'h101C, 3, 0, 0, 0, 0, rq, st);
    check32("exc_in_stall_cycles", st, 0);

    // lhu 0x200, lw 0x204, sb 0x101
    exp_bus(32'h200, 0, 4'b0011, 0);
    exp_wb(32'h1020, 32'h0000F234, 4, 1, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 3'b101, 32'h200, 0, 32'h1020, 4, 1, 0, 32'h8001F234, 0, rq, st);
    exp_bus(32'h204, 0, 4'hF, 0);
    exp_wb(32'h1024, 32'hCAFEF00D, 6, 1, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 3'b010, 32'h204, 0, 32'h1024, 6, 1, 3, 32'hCAFEF00D, 0, rq, st);
    check32("lw_stall_cycles", st, 5);
    exp_bus(32'h100, 1, 4'b0010, 32'h44444444);
    exp_wb(32'h1028, 32'h11223344, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 3'b000, 32'h101, 32'h11223344, 32'h1028, 0, 0, 0, 0, 0, rq, st);

    // Flush while BUSY: request held until ack, result discarded
    exp_bus(32'h300, 0, 4'hF, 0);
    mem_re_i = 1; opfunc3_i = 3'b010; mem_addr_i = 32'h300; pc_i = 32'h2000;
    rd_addr_i = 9; rd_we_i = 1;
    @(negedge clk_i); check32("fl_stall_c0", {31'b0, mem_stall_o}, 1);
    @(posedge clk_i); #1; flush_i = 1;
    @(negedge clk_i); check32("fl_req_c1", {31'b0, bus_req_o}, 1);
    @(posedge clk_i); #1; flush_i = 0; clear_inputs();
    @(negedge clk_i);
    check32("fl_req_c2", {31'b0, bus_req_o}, 1);
    check32("fl_stall_c2", {31'b0, mem_stall_o}, 1);
    @(posedge clk_i); #1; bus_ack_i = 1; bus_rdata_i = 32'h12345678;
    @(negedge clk_i); check32("fl_req_c3", {31'b0, bus_req_o}, 1);
    @(posedge clk_i); #1; bus_ack_i = 0; bus_rdata_i = 0;
    @(negedge clk_i);
    check32("fl_req_after", {31'b0, bus_req_o}, 0);
    check32("fl_stall_after", {31'b0, mem_stall_o}, 0);
    check32("fl_pc_bubble", pc_o, 0);
    check32("fl_rd_we_bubble", {31'b0, rd_we_o}, 0);
    @(posedge clk_i); #1;

    // lbu 0x203 straight after, with a two-cycle stall in DONE
    exp_bus(32'h200, 0, 4'b1000, 0);
    exp_wb(32'h2004, 32'h00000080, 10, 1, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 3'b100, 32'h203, 0, 32'h2004, 10, 1, 0, 32'h80FF1234, 2, rq, st);
    check32("lbu_stall_cycles", st, 2);

    // Reset while BUSY drops the request on the next cycle
    exp_bus(32'h400, 1, 4'hF, 32'h11111111);
    mem_we_i = 1; opfunc3_i = 3'b010; mem_addr_i = 32'h400; rd_data_i = 32'h11111111;
    pc_i = 32'h3000;
    @(posedge clk_i); #1; rst_i = 1;
    @(negedge clk_i); check32("rst_busy_req", {31'b0, bus_req_o}, 1);
    @(posedge clk_i); #1; rst_i = 0; clear_inputs();
    @(negedge clk_i);
    check32("rst_busy_req_after", {31'b0, bus_req_o}, 0);
    check32("rst_busy_pc", pc_o, 0);
    @(posedge clk_i); #1;

    // Stage still works after the reset
    exp_bus(32'h404, 0, 4'hF, 0);
    exp_wb(32'h3004, 32'h0BADF00D, 11, 1, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 3'b010, 32'h404, 0, 32'h3004, 11, 1, 1, 32'h0BADF00D, 0, rq, st);
    check32("post_rst_req_cycles", rq, 2);

    repeat (3) @(posedge clk_i);
    #1;
    check32("bus_q_empty", bus_q.size(), 0);
    check32("wb_q_empty", wb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
